// File: rtl/ex_div_sequencer_if.sv
// Execute-stage divide handshake: ID/EX operands and flush in, stall and
// one-cycle result out.
interface ex_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             divStart_IDEX;
  logic             divSigned_IDEX;
  logic             divRem_IDEX;
  logic [WIDTH-1:0] dividend_IDEX;
  logic [WIDTH-1:0] divisor_IDEX;
  logic             flush_EX;
  logic             stall_EX;
  logic             div_busy;
  logic             div_valid;
  logic [WIDTH-1:0] div_result;

  modport master (
    output divStart_IDEX, divSigned_IDEX, divRem_IDEX,
           dividend_IDEX, divisor_IDEX, flush_EX,
    input  stall_EX, div_busy, div_valid, div_result
  );

  modport slave (
    input  divStart_IDEX, divSigned_IDEX, divRem_IDEX,
           dividend_IDEX, divisor_IDEX, flush_EX,
    output stall_EX, div_busy, div_valid, div_result
  );
endinterface

// File: rtl/ex_div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the execute stage with RISC-V
// divide/remainder semantics; stalls the pipeline front while iterating.
module ex_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_div_sequencer_if.slave    bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  dsr_q;
  logic [WIDTH:0]    rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  result_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              sel_rem_q;

  logic              stall;
  logic              busy;
  logic              valid;
  logic              load;
  logic              step;
  logic              last_step;

  // Operand conditioning: magnitudes for signed ops, raw values otherwise.
  logic              dvd_neg;
  logic              dsr_neg;
  logic              dsr_zero;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dsr_mag;
  logic [WIDTH-1:0]  zero_div_result;

  assign dvd_neg  = bus.divSigned_IDEX & bus.dividend_IDEX[WIDTH-1];
  assign dsr_neg  = bus.divSigned_IDEX & bus.divisor_IDEX[WIDTH-1];
  assign dsr_zero = (bus.divisor_IDEX == '0);
  assign dvd_mag  = dvd_neg ? (~bus.dividend_IDEX + 1'b1) : bus.dividend_IDEX;
  assign dsr_mag  = dsr_neg ? (~bus.divisor_IDEX + 1'b1) : bus.divisor_IDEX;

  // Divide by zero: quotient all ones, remainder is the untouched dividend.
  assign zero_div_result = bus.divRem_IDEX ? bus.dividend_IDEX : '1;

  // One restoring iteration; the accumulator carries an extra bit so the
  // shifted partial remainder can be compared without overflow.
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    rem_step;
  logic [WIDTH-1:0]  quo_step;
  logic              take;
  logic [WIDTH-1:0]  fin_quo;
  logic [WIDTH-1:0]  fin_rem;

  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign take      = (rem_shift >= {1'b0, dsr_q});
  assign rem_step  = take ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
  assign quo_step  = {quo_q[WIDTH-2:0], take};
  assign fin_quo   = neg_quo_q ? (~quo_step + 1'b1) : quo_step;
  assign fin_rem   = neg_rem_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
  assign last_step = (cnt_q == CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    busy    = 1'b0;
    valid   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.divStart_IDEX && !bus.flush_EX) begin
          stall   = 1'b1;
          load    = 1'b1;
          state_d = dsr_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (bus.flush_EX) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (last_step) state_d = DONE;
        end
      end
      DONE: begin
        // Flush kills the result; the pipeline advances either way.
        valid   = !bus.flush_EX;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else if (load) begin
      quo_q     <= dvd_mag;
      dsr_q     <= dsr_mag;
      rem_q     <= '0;
      cnt_q     <= CNT_W'(WIDTH);
      neg_quo_q <= dvd_neg ^ dsr_neg;
      neg_rem_q <= dvd_neg;
      sel_rem_q <= bus.divRem_IDEX;
      if (dsr_zero) result_q <= zero_div_result;
    end else if (step) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) result_q <= sel_rem_q ? fin_rem : fin_quo;
    end
  end

  assign bus.stall_EX   = stall;
  assign bus.div_busy   = busy;
  assign bus.div_valid  = valid;
  assign bus.div_result = valid ? result_q : '0;
endmodule

// File: tb/tb_ex_div_sequencer.sv
// Scoreboard bench for ex_div_sequencer: expected results are queued when an
// op is issued and compared when div_valid pulses.
module tb_ex_div_sequencer;
  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] MIN_VAL = 32'h8000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [WIDTH-1:0] exp_q[$];

  ex_div_sequencer_if #(.WIDTH(WIDTH)) dif ();

  ex_div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference arithmetic (RISC-V DIV/DIVU/REM/REMU).
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, b,
                                             input logic sgn, rm);
    logic [WIDTH-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn && a == MIN_VAL && b == '1) begin
      q = MIN_VAL;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  task automatic idle_inputs();
    dif.divStart_IDEX  = 1'b0;
    dif.divSigned_IDEX = 1'b0;
    dif.divRem_IDEX    = 1'b0;
    dif.dividend_IDEX  = '0;
    dif.divisor_IDEX   = '0;
    dif.flush_EX       = 1'b0;
  endtask

  // Issue one op, then scramble the ID/EX inputs while it runs.
  task automatic start_op(input logic [WIDTH-1:0] a, b, input logic sgn, rm);
    @(posedge clk); #1;
    dif.divStart_IDEX  = 1'b1;
    dif.divSigned_IDEX = sgn;
    dif.divRem_IDEX    = rm;
    dif.dividend_IDEX  = a;
    dif.divisor_IDEX   = b;
  endtask

  task automatic scramble();
    dif.divStart_IDEX  = 1'b0;
    dif.divSigned_IDEX = ~dif.divSigned_IDEX;
    dif.divRem_IDEX    = ~dif.divRem_IDEX;
    dif.dividend_IDEX  = $urandom;
    dif.divisor_IDEX   = $urandom;
  endtask

  task automatic run_div(input string tag, input logic [WIDTH-1:0] a, b,
                         input logic sgn, rm);
    int   cyc;
    bit   done;
    logic stall_ok;
    logic [WIDTH-1:0] exp_res;
    exp_q.push_back(model(a, b, sgn, rm));
    start_op(a, b, sgn, rm);
    @(negedge clk);
    stall_ok = dif.stall_EX;
    @(posedge clk); #1;
    scramble();
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy"}, WIDTH'(dif.div_busy), WIDTH'(b != '0));
      if (dif.div_valid) done = 1'b1;
      else begin
        stall_ok = stall_ok & dif.stall_EX;
        cyc++;
      end
    end
    check({tag, "_latency"}, WIDTH'(cyc), (b == '0) ? WIDTH'(1) : WIDTH'(WIDTH + 1));
    check({tag, "_stall_run"}, WIDTH'(stall_ok), WIDTH'(1));
    exp_res = exp_q.pop_front();
    if (done) begin
      check({tag, "_stall_done"}, WIDTH'(dif.stall_EX), WIDTH'(0));
      check({tag, "_result"}, dif.div_result, exp_res);
    end
  endtask

  // Watch for any div_valid over a window; returns the number seen.
  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dif.div_valid) seen++;
    end
  endtask

  initial begin
    int seen;
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_stall", WIDTH'(dif.stall_EX), WIDTH'(0));
    check("reset_busy", WIDTH'(dif.div_busy), WIDTH'(0));
    check("reset_valid", WIDTH'(dif.div_valid), WIDTH'(0));
    check("reset_result", dif.div_result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u100_7_q", 32'd100, 32'd7, 1'b0, 1'b0);
    run_div("s-7_2_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div("s-7_2_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    run_div("z_u_q", 32'h1234, 32'd0, 1'b0, 1'b0);
    run_div("z_u_r", 32'h1234, 32'd0, 1'b0, 1'b1);
    run_div("z_s_r", 32'hFFFF_FF00, 32'd0, 1'b1, 1'b1);
    run_div("ovf_s_q", MIN_VAL, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div("ovf_s_r", MIN_VAL, 32'hFFFF_FFFF, 1'b1, 1'b1);
    run_div("ovf_u_q", MIN_VAL, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_div("ovf_u_r", MIN_VAL, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_div("s7_-2_r", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom_range(1, 1000);
      run_div($sformatf("rnd%0d", i), ra, rb, 1'(i % 2), 1'(i / 2));
    end

    // Flush in CALC cycle 10.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    @(posedge clk); #1;
    scramble();
    repeat (9) @(posedge clk);
    #1 dif.flush_EX = 1'b1;
    @(negedge clk);
    check("flush_stall", WIDTH'(dif.stall_EX), WIDTH'(0));
    check("flush_valid", WIDTH'(dif.div_valid), WIDTH'(0));
    @(posedge clk); #1;
    dif.flush_EX = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", WIDTH'(dif.div_busy), WIDTH'(0));
    count_valid(40, seen);
    check("flush_no_valid", WIDTH'(seen), WIDTH'(0));
    run_div("after_flush_q", 32'd20, 32'd3, 1'b0, 1'b0);

    // Flush on the DONE cycle of a zero-divide op suppresses the result.
    start_op(32'h55, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    scramble();
    dif.flush_EX = 1'b1;
    @(negedge clk);
    check("flush_done_valid", WIDTH'(dif.div_valid), WIDTH'(0));
    check("flush_done_result", dif.div_result, '0);
    @(posedge clk); #1;
    dif.flush_EX = 1'b0;
    count_valid(5, seen);
    check("flush_done_no_valid", WIDTH'(seen), WIDTH'(0));

    // Asynchronous reset in CALC cycle 5.
    start_op(32'd1000, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    scramble();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_stall", WIDTH'(dif.stall_EX), WIDTH'(0));
    check("rst_mid_busy", WIDTH'(dif.div_busy), WIDTH'(0));
    check("rst_mid_valid", WIDTH'(dif.div_valid), WIDTH'(0));
    check("rst_mid_result", dif.div_result, '0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    count_valid(40, seen);
    check("rst_no_valid", WIDTH'(seen), WIDTH'(0));
    run_div("after_rst_q", 32'd20, 32'd3, 1'b0, 1'b0);

    check("scoreboard_empty", WIDTH'(exp_q.size()), WIDTH'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
